// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator for the VGA pipeline.
// It produces the scan coordinates, the sync levels, the visible flag,
// the line/frame markers and a frame counter. Every output is registered
// and describes the coordinate pair loaded on the same clock edge.
module vga_timing_gen #(
    parameter int CLK_DIV     = 2,
    parameter int H_VIS       = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VIS       = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SYNC_ACTIVE = 0
) (
    input  logic        clk,
    input  logic        resetN,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        hsync,
    output logic        vsync,
    output logic        visible,
    output logic        pixelTick,
    output logic        startOfFrame,
    output logic        startOfLine,
    output logic [15:0] frameCount
);

    localparam int H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HS_FIRST = H_VIS + H_FP;
    localparam int HS_LAST  = H_VIS + H_FP + H_SYNC - 1;
    localparam int VS_FIRST = V_VIS + V_FP;
    localparam int VS_LAST  = V_VIS + V_FP + V_SYNC - 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [10:0]      X_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0]      Y_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0]      CNT_ONE  = 11'd1;
    localparam logic             SYNC_ON  = (SYNC_ACTIVE != 0) ? 1'b1 : 1'b0;
    localparam logic             SYNC_OFF = (SYNC_ACTIVE != 0) ? 1'b0 : 1'b1;

    // Inclusive range test on a coordinate; an empty range (hi < lo) never matches.
    function automatic logic in_window(input logic [10:0] v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) <= hi);
    endfunction

    logic [DIV_W-1:0] div_r;
    logic             tick_s;
    logic [10:0]      x_nx_s;
    logic [10:0]      y_nx_s;
    logic             sol_nx_s;
    logic             sof_nx_s;

    logic [10:0]      x_r;
    logic [10:0]      y_r;
    logic             hsync_r;
    logic             vsync_r;
    logic             visible_r;
    logic             tick_r;
    logic             sof_r;
    logic             sol_r;
    logic [15:0]      frame_count_r;

    // Pixel tick: the edge on which the divider sits at its last count.
    always_comb begin
        tick_s = (div_r == DIV_LAST);
    end

    // Next coordinate pair; any out-of-range value is treated as the wrap point
    // so the counters can never run past the raster.
    always_comb begin
        x_nx_s = x_r;
        y_nx_s = y_r;
        if (x_r >= X_LAST) begin
            x_nx_s = 11'd0;
            if (y_r >= Y_LAST) begin
                y_nx_s = 11'd0;
            end else begin
                y_nx_s = y_r + CNT_ONE;
            end
        end else begin
            x_nx_s = x_r + CNT_ONE;
        end
    end

    // Line and frame start markers for the coordinate that is about to load.
    always_comb begin
        sol_nx_s = (x_nx_s == 11'd0);
        sof_nx_s = (x_nx_s == 11'd0) && (y_nx_s == 11'd0);
    end

    // Clock divider producing one pixel tick every CLK_DIV clocks.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            div_r <= '0;
        end else if (tick_s) begin
            div_r <= '0;
        end else begin
            div_r <= div_r + DIV_ONE;
        end
    end

    // Coordinates, syncs, visible flag, markers and frame counter, all loaded
    // together so each flag describes the coordinate beside it.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            x_r           <= X_LAST;
            y_r           <= Y_LAST;
            hsync_r       <= SYNC_OFF;
            vsync_r       <= SYNC_OFF;
            visible_r     <= 1'b0;
            tick_r        <= 1'b0;
            sof_r         <= 1'b0;
            sol_r         <= 1'b0;
            frame_count_r <= 16'd0;
        end else if (tick_s) begin
            x_r       <= x_nx_s;
            y_r       <= y_nx_s;
            hsync_r   <= in_window(x_nx_s, HS_FIRST, HS_LAST) ? SYNC_ON : SYNC_OFF;
            vsync_r   <= in_window(y_nx_s, VS_FIRST, VS_LAST) ? SYNC_ON : SYNC_OFF;
            visible_r <= in_window(x_nx_s, 0, H_VIS - 1) && in_window(y_nx_s, 0, V_VIS - 1);
            tick_r    <= 1'b1;
            sof_r     <= sof_nx_s;
            sol_r     <= sol_nx_s;
            if (sof_nx_s) begin
                frame_count_r <= frame_count_r + 16'd1;
            end else begin
                frame_count_r <= frame_count_r;
            end
        end else begin
            tick_r <= 1'b0;
            sof_r  <= 1'b0;
            sol_r  <= 1'b0;
        end
    end

    assign pixelX       = x_r;
    assign pixelY       = y_r;
    assign hsync        = hsync_r;
    assign vsync        = vsync_r;
    assign visible      = visible_r;
    assign pixelTick    = tick_r;
    assign startOfFrame = sof_r;
    assign startOfLine  = sol_r;
    assign frameCount   = frame_count_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small-raster instance (CLK_DIV=2) checked
// cycle by cycle against a reference model through an expectation queue,
// a CLK_DIV=1 positive-sync instance and a default 640x480 instance.
module tb_vga_timing_gen;

    localparam int HV = 8, HF = 2, HS = 3, HB = 3;
    localparam int VV = 6, VF = 1, VS = 2, VB = 1;
    localparam int HT = HV + HF + HS + HB;   // 16
    localparam int VT = VV + VF + VS + VB;   // 10
    localparam int DIV_A = 2;

    logic clk = 1'b0;
    logic resetN = 1'b1;
    always #5 clk = ~clk;

    logic [10:0] a_x, a_y, b_x, b_y, d_x, d_y;
    logic        a_hs, a_vs, a_vis, a_tick, a_sof, a_sol;
    logic        b_hs, b_vs, b_vis, b_tick, b_sof, b_sol;
    logic        d_hs, d_vs, d_vis, d_tick, d_sof, d_sol;
    logic [15:0] a_fc, b_fc, d_fc;

    vga_timing_gen #(.CLK_DIV(DIV_A), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_ACTIVE(0)) u_a (
        .clk(clk), .resetN(resetN), .pixelX(a_x), .pixelY(a_y), .hsync(a_hs), .vsync(a_vs),
        .visible(a_vis), .pixelTick(a_tick), .startOfFrame(a_sof), .startOfLine(a_sol),
        .frameCount(a_fc));

    vga_timing_gen #(.CLK_DIV(1), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_ACTIVE(1)) u_b (
        .clk(clk), .resetN(resetN), .pixelX(b_x), .pixelY(b_y), .hsync(b_hs), .vsync(b_vs),
        .visible(b_vis), .pixelTick(b_tick), .startOfFrame(b_sof), .startOfLine(b_sol),
        .frameCount(b_fc));

    vga_timing_gen u_d (
        .clk(clk), .resetN(resetN), .pixelX(d_x), .pixelY(d_y), .hsync(d_hs), .vsync(d_vs),
        .visible(d_vis), .pixelTick(d_tick), .startOfFrame(d_sof), .startOfLine(d_sol),
        .frameCount(d_fc));

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        hs;
        logic        vs;
        logic        vis;
        logic        tick;
        logic        sof;
        logic        sol;
        logic [15:0] fc;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic rst_edge = 1'b0;

    // reference model state for u_a
    int m_div, m_x, m_y, m_fc;

    // statistics gathered per frame / per line
    int a_flen, a_fhs, a_fvs, a_fvis, a_last_len, a_last_hs, a_last_vs, a_last_vis, a_sof_n;
    int d_llen, d_lhs, d_lvis, d_last_len, d_last_hs, d_last_vis, d_sol_n;
    int b_llen, b_lhs, b_last_len, b_last_hs;

    task automatic model_reset();
        m_div = 0;
        m_x   = HT - 1;
        m_y   = VT - 1;
        m_fc  = 0;
    endtask

    task automatic stats_clear();
        a_flen = 0; a_fhs = 0; a_fvs = 0; a_fvis = 0; a_sof_n = 0;
        a_last_len = 0; a_last_hs = 0; a_last_vs = 0; a_last_vis = 0;
        d_llen = 0; d_lhs = 0; d_lvis = 0; d_sol_n = 0;
        d_last_len = 0; d_last_hs = 0; d_last_vis = 0;
        b_llen = 0; b_lhs = 0; b_last_len = 0; b_last_hs = 0;
    endtask

    function automatic obs_t model_obs(input logic tick, input logic sol, input logic sof);
        obs_t o;
        o.x    = 11'(m_x);
        o.y    = 11'(m_y);
        o.hs   = (m_x >= HV + HF && m_x <= HV + HF + HS - 1) ? 1'b0 : 1'b1;
        o.vs   = (m_y >= VV + VF && m_y <= VV + VF + VS - 1) ? 1'b0 : 1'b1;
        o.vis  = (m_x < HV && m_y < VV) ? 1'b1 : 1'b0;
        o.tick = tick;
        o.sof  = sof;
        o.sol  = sol;
        o.fc   = 16'(m_fc);
        return o;
    endfunction

    // One clock: advance the model at the edge, compare at the falling edge.
    task automatic cycle();
        obs_t e;
        obs_t g;
        logic l;
        logic f;
        @(posedge clk);
        rst_edge = resetN;
        if (!resetN) begin
            model_reset();
            exp_q.push_back(model_obs(1'b0, 1'b0, 1'b0));
        end else if (m_div == DIV_A - 1) begin
            m_div = 0;
            if (m_x == HT - 1) begin
                m_x = 0;
                m_y = (m_y == VT - 1) ? 0 : m_y + 1;
            end else begin
                m_x = m_x + 1;
            end
            l = (m_x == 0);
            f = l && (m_y == 0);
            if (f) m_fc = (m_fc + 1) % 65536;
            exp_q.push_back(model_obs(1'b1, l, f));
        end else begin
            m_div = m_div + 1;
            exp_q.push_back(model_obs(1'b0, 1'b0, 1'b0));
        end
        @(negedge clk);
        cyc++;
        g = {a_x, a_y, a_hs, a_vs, a_vis, a_tick, a_sof, a_sol, a_fc};
        e = exp_q.pop_front();
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL sb_dut0 cyc=%0d got x=%0d y=%0d hs=%b vs=%b vis=%b tick=%b sof=%b sol=%b fc=%0d exp x=%0d y=%0d hs=%b vs=%b vis=%b tick=%b sof=%b sol=%b fc=%0d",
                     cyc, g.x, g.y, g.hs, g.vs, g.vis, g.tick, g.sof, g.sol, g.fc,
                     e.x, e.y, e.hs, e.vs, e.vis, e.tick, e.sof, e.sol, e.fc);
        end
        checks++;
        if (b_hs !== ((b_x >= 11'd10 && b_x <= 11'd12) ? 1'b1 : 1'b0)) begin
            failures++;
            $display("FAIL b_hsync cyc=%0d x=%0d got=%b", cyc, b_x, b_hs);
        end
        if (rst_edge) begin
            checks++;
            if (b_tick !== 1'b1) begin
                failures++;
                $display("FAIL b_tick cyc=%0d got=%b exp=1", cyc, b_tick);
            end
        end
        checks++;
        if (d_vis !== ((d_x < 11'd640 && d_y < 11'd480) ? 1'b1 : 1'b0)) begin
            failures++;
            $display("FAIL d_visible cyc=%0d x=%0d y=%0d got=%b", cyc, d_x, d_y, d_vis);
        end
        checks++;
        if (d_x > 11'd799 || d_y > 11'd524 || b_x >= 11'(HT) || b_y >= 11'(VT)) begin
            failures++;
            $display("FAIL bounds cyc=%0d d=(%0d,%0d) b=(%0d,%0d)", cyc, d_x, d_y, b_x, b_y);
        end
        if (a_sof) begin
            a_last_len = a_flen; a_last_hs = a_fhs; a_last_vs = a_fvs; a_last_vis = a_fvis;
            a_flen = 0; a_fhs = 0; a_fvs = 0; a_fvis = 0; a_sof_n++;
        end
        a_flen++;
        if (!a_hs) a_fhs++;
        if (!a_vs) a_fvs++;
        if (a_vis && a_tick) a_fvis++;
        if (d_sol) begin
            d_last_len = d_llen; d_last_hs = d_lhs; d_last_vis = d_lvis;
            d_llen = 0; d_lhs = 0; d_lvis = 0; d_sol_n++;
        end
        d_llen++;
        if (!d_hs) d_lhs++;
        if (d_vis) d_lvis++;
        if (b_sol) begin
            b_last_len = b_llen; b_last_hs = b_lhs;
            b_llen = 0; b_lhs = 0;
        end
        b_llen++;
        if (b_hs) b_lhs++;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 10; i++) begin
            cycle();
            checks++;
            if ({d_x, d_y, d_hs, d_vs, d_vis, d_tick, d_sof, d_sol, d_fc} !==
                {11'd799, 11'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0}) begin
                failures++;
                $display("FAIL reset_def i=%0d got x=%0d y=%0d hs=%b vs=%b vis=%b fc=%0d", i, d_x, d_y, d_hs, d_vs, d_vis, d_fc);
            end
            checks++;
            if ({b_x, b_y, b_hs, b_vs, b_vis, b_tick, b_sof, b_sol, b_fc} !==
                {11'd15, 11'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0}) begin
                failures++;
                $display("FAIL reset_pos i=%0d got x=%0d y=%0d hs=%b vs=%b tick=%b fc=%0d", i, b_x, b_y, b_hs, b_vs, b_tick, b_fc);
            end
        end
    endtask

    task automatic test_first_tick();
        stats_clear();
        resetN = 1'b1;
        cycle();
        checks++;
        if ({b_x, b_y, b_sof, b_sol, b_tick, b_fc, a_x, a_tick} !==
            {11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 16'd1, 11'd15, 1'b0}) begin
            failures++;
            $display("FAIL first_edge got b=(%0d,%0d) sof=%b fc=%0d a_x=%0d a_tick=%b exp b=(0,0) sof=1 fc=1 a_x=15 a_tick=0",
                     b_x, b_y, b_sof, b_fc, a_x, a_tick);
        end
        cycle();
        checks++;
        if ({a_x, a_y, a_sof, a_sol, a_vis, a_fc} !== {11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 16'd1}) begin
            failures++;
            $display("FAIL first_tick_a got (%0d,%0d) sof=%b sol=%b vis=%b fc=%0d exp (0,0) 1 1 1 1", a_x, a_y, a_sof, a_sol, a_vis, a_fc);
        end
        checks++;
        if ({d_x, d_y, d_sof, d_vis, d_hs, d_fc} !== {11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 16'd1}) begin
            failures++;
            $display("FAIL first_tick_def got (%0d,%0d) sof=%b vis=%b hs=%b fc=%0d exp (0,0) 1 1 1 1", d_x, d_y, d_sof, d_vis, d_hs, d_fc);
        end
        cycle();
        checks++;
        if ({a_x, a_sof, a_sol, a_tick, a_fc} !== {11'd0, 1'b0, 1'b0, 1'b0, 16'd1}) begin
            failures++;
            $display("FAIL pulse_width got x=%0d sof=%b sol=%b tick=%b fc=%0d exp 0 0 0 0 1", a_x, a_sof, a_sol, a_tick, a_fc);
        end
    endtask

    task automatic test_line_and_frame();
        for (int i = 0; i < 1650; i++) cycle();
        checks++;
        if ({d_sol_n, d_last_len, d_last_hs, d_last_vis} !== {32'sd2, 32'sd1600, 32'sd192, 32'sd1280}) begin
            failures++;
            $display("FAIL line_def got lines=%0d len=%0d hs_low=%0d vis=%0d exp 2 1600 192 1280", d_sol_n, d_last_len, d_last_hs, d_last_vis);
        end
        checks++;
        if ({a_sof_n, a_last_len, a_last_hs, a_last_vs, a_last_vis} !== {32'sd6, 32'sd320, 32'sd60, 32'sd64, 32'sd48}) begin
            failures++;
            $display("FAIL frame_a got frames=%0d len=%0d hs_low=%0d vs_low=%0d vis_ticks=%0d exp 6 320 60 64 48",
                     a_sof_n, a_last_len, a_last_hs, a_last_vs, a_last_vis);
        end
        checks++;
        if ({b_last_len, b_last_hs} !== {32'sd16, 32'sd3}) begin
            failures++;
            $display("FAIL line_pos got len=%0d hs_high=%0d exp 16 3", b_last_len, b_last_hs);
        end
    endtask

    task automatic test_async_reset();
        int i;
        for (i = 0; i < 400 && !(m_x == 5 && m_y == 3); i++) cycle();
        checks++;
        if (!(m_x == 5 && m_y == 3)) begin
            failures++;
            $display("FAIL async_seek timeout got (%0d,%0d) exp (5,3)", m_x, m_y);
        end
        #2;
        resetN = 1'b0;
        #1;
        checks++;
        if ({a_x, a_y, a_hs, a_vs, a_vis, a_tick, a_sof, a_sol, a_fc} !==
            {11'd15, 11'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0}) begin
            failures++;
            $display("FAIL async_reset_a got x=%0d y=%0d hs=%b vs=%b vis=%b fc=%0d exp 15 9 1 1 0 0", a_x, a_y, a_hs, a_vs, a_vis, a_fc);
        end
        checks++;
        if ({d_x, d_y, d_fc} !== {11'd799, 11'd524, 16'd0}) begin
            failures++;
            $display("FAIL async_reset_def got x=%0d y=%0d fc=%0d exp 799 524 0", d_x, d_y, d_fc);
        end
        for (int k = 0; k < 3; k++) cycle();
        resetN = 1'b1;
        cycle();
        cycle();
        checks++;
        if ({a_x, a_y, a_sof, a_fc} !== {11'd0, 11'd0, 1'b1, 16'd1}) begin
            failures++;
            $display("FAIL restart got (%0d,%0d) sof=%b fc=%0d exp (0,0) 1 1", a_x, a_y, a_sof, a_fc);
        end
    endtask

    task automatic test_fc_wrap();
        int n;
        logic [15:0] seen0;
        logic [15:0] seen1;
        n = 0;
        seen0 = 16'd0;
        seen1 = 16'd0;
        force u_b.frame_count_r = 16'hFFFE;
        #1;
        release u_b.frame_count_r;
        for (int i = 0; i < 400 && n < 2; i++) begin
            cycle();
            if (b_sof) begin
                if (n == 0) seen0 = b_fc;
                else seen1 = b_fc;
                n++;
            end
        end
        checks++;
        if (n != 2) begin
            failures++;
            $display("FAIL fc_wrap_timeout got frames=%0d exp 2", n);
        end
        checks++;
        if ({seen0, seen1} !== {16'hFFFF, 16'h0000}) begin
            failures++;
            $display("FAIL fc_wrap got %0d then %0d exp 65535 then 0", seen0, seen1);
        end
    endtask

    initial begin
        model_reset();
        stats_clear();
        #1;
        resetN = 1'b0;
        test_reset();
        test_first_tick();
        test_line_and_frame();
        test_async_reset();
        test_fc_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
